rtc_time_keeper: RTL and testbench
==================================

// Module: rtc_time_keeper
// PURPOSE
//  Parametrised hh:mm:ss time-of-day counter with time load, 12/24-hour display mode and an alarm with snooze.
//  Runs on the 1 Hz tick domain; replaces the free-running sec/min counter feeding the display mux.
//  Presents packed BCD hours/minutes/seconds plus minute/hour strobes and an alarm ringing flag.
// PARAMETERS
//  HOUR_MODE   24   display format: 24 -> hr_bcd 00..23; 12 -> hr_bcd 01..12 with pm flag
//  RING_SEC    60   max cycles ringing stays high before auto-stop (1..255)
//  SNOOZE_SEC  300  cycles spent in SNOOZE before re-ringing (1..1023)
// PORTS
//  clk_1Hz    in   1  time-base clock, one edge per second
//  rst        in   1  reset, asynchronous, active-high
//  run        in   1  1 = advance time each edge; 0 = hold time (alarm FSM still runs)
//  set_valid  in   1  load set_hr/set_min/set_sec this edge
//  set_hr     in   5  load hour, binary 0..23 (always 24 h form)
//  set_min    in   6  load minute, binary 0..59
//  set_sec    in   6  load second, binary 0..59
//  alarm_set  in   1  latch alarm_hr/alarm_min this edge
//  alarm_hr   in   5  alarm hour, binary 0..23
//  alarm_min  in   6  alarm minute, binary 0..59
//  alarm_on   in   1  alarm armed; low forces FSM to IDLE
//  snooze     in   1  snooze request while ringing
//  stop       in   1  silence alarm (priority over snooze)
//  hr_bcd     out  8  hours, {tens,units} BCD per HOUR_MODE
//  min_bcd    out  8  minutes BCD
//  sec_bcd    out  8  seconds BCD
//  pm         out  1  12 h mode: 1 for internal hour 12..23; tied 0 in 24 h mode
//  tick_min   out  1  one-cycle pulse, high in the cycle after sec wraps 59->0
//  tick_hr    out  1  one-cycle pulse, high in the cycle after min wraps 59->0
//  ringing    out  1  high while FSM in RINGING
//  set_err    out  1  one-cycle pulse: a set_valid or alarm_set carried out-of-range value
// BEHAVIOUR
//  - Reset: time 00:00:00, alarm 00:00, FSM IDLE, all counters 0; sec_bcd=min_bcd=8'h00, hr_bcd=8'h00 (24) or 8'h12 (12),
//    pm=0, tick_min=tick_hr=ringing=set_err=0. rst mid-ring or mid-snooze returns to IDLE immediately.
//  - Internal state binary (hr 0..23, min/sec 0..59); BCD/pm outputs are combinational decodes of registered state,
//    valid after the edge that updates it (zero added latency).
//  - Per-edge priority: rst > valid set_valid load > run increment. Load edge performs no increment.
//  - Increment: sec+1; 59 -> 0 carries min; min 59 -> 0 carries hr; hr 23 -> 0. 23:59:59 -> 00:00:00 in one edge.
//  - Load validation: any of set_hr>23, set_min>59, set_sec>59 -> no load, set_err=1 next cycle, time continues per run.
//    Same rule for alarm_set (alarm_hr>23 or alarm_min>59). Both strobes in one edge handled independently.
//  - 12 h decode: hr 0 -> 12 pm=0; 1..11 -> same, pm=0; 12 -> 12 pm=1; 13..23 -> hr-12, pm=1.
//  - tick_min/tick_hr only from counting carries, never from loads; both high together on hour rollover.
//  - Alarm FSM states IDLE, RINGING, SNOOZE:
//    IDLE -> RINGING when alarm_on and an increment produces hh:mm:00 equal to alarm (loads never trigger); ring_cnt=RING_SEC-1.
//    RINGING: stop or !alarm_on -> IDLE; else snooze -> SNOOZE, snz_cnt=SNOOZE_SEC-1; else ring_cnt==0 -> IDLE; else ring_cnt-1.
//    SNOOZE: stop or !alarm_on -> IDLE; snz_cnt==0 -> RINGING (ring_cnt reloaded); else snz_cnt-1. Counts regardless of run.
//    A match occurring while in SNOOZE or RINGING is ignored.
//  - Counter widths: ring_cnt 8 bit, snz_cnt 10 bit; no wrap beyond 0.
// TESTING
//  1. rst, run=1, 60 edges -> sec_bcd 00..59 -> 00, min_bcd=8'h01, tick_min pulses once.
//  2. Load 23:59:58, run=1, 2 edges -> 00:00:00, tick_min and tick_hr high together, 12 h build shows hr_bcd=8'h12 pm=0.
//  3. set_valid with set_min=60 -> set_err one cycle, time unchanged except normal increment; set_hr=13 in 12 h build -> hr_bcd 8'h01 pm=1.
//  4. Alarm 07:30, alarm_on=1, load 07:29:59, 1 edge -> ringing=1 next cycle; no input -> ringing drops after RING_SEC edges.
//  5. While ringing: snooze -> ringing 0 for SNOOZE_SEC edges then 1; snooze+stop same edge -> IDLE, no re-ring.
//  6. Assert rst asynchronously during SNOOZE and during run -> outputs to reset values without a clock edge.

Source files
------------

// File: rtl/rtc_time_keeper_if.sv
// Control and display bundle for the 1 Hz time-of-day keeper.
// master drives time/alarm controls; slave is the keeper itself.
interface rtc_time_keeper_if;
  logic       run;
  logic       set_valid;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       alarm_set;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_on;
  logic       snooze;
  logic       stop;
  logic [7:0] hr_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       pm;
  logic       tick_min;
  logic       tick_hr;
  logic       ringing;
  logic       set_err;

  modport master (
    output run, set_valid, set_hr, set_min, set_sec, alarm_set, alarm_hr, alarm_min,
           alarm_on, snooze, stop,
    input  hr_bcd, min_bcd, sec_bcd, pm, tick_min, tick_hr, ringing, set_err
  );

  modport slave (
    input  run, set_valid, set_hr, set_min, set_sec, alarm_set, alarm_hr, alarm_min,
           alarm_on, snooze, stop,
    output hr_bcd, min_bcd, sec_bcd, pm, tick_min, tick_hr, ringing, set_err
  );
endinterface

// File: rtl/rtc_time_keeper.sv
// hh:mm:ss time-of-day counter on the 1 Hz tick with load, 12/24 h decode
// and an alarm that rings, snoozes and auto-stops.
module rtc_time_keeper #(
  parameter int unsigned HOUR_MODE  = 24,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input logic              clk_1Hz,
  input logic              rst,
  rtc_time_keeper_if.slave tk_io
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRinging = 2'd1;
  localparam logic [1:0] StSnooze  = 2'd2;

  localparam logic [7:0] RingLoad = 8'(RING_SEC - 1);
  localparam logic [9:0] SnzLoad  = 10'(SNOOZE_SEC - 1);

  logic [4:0] hr_q, hr_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [4:0] alm_hr_q, alm_hr_d;
  logic [5:0] alm_min_q, alm_min_d;
  logic [1:0] st_q, st_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic       tick_min_q, tick_min_d;
  logic       tick_hr_q, tick_hr_d;
  logic       set_err_q, set_err_d;

  logic set_ok, alm_ok, inc, sec_wrap, min_wrap, match;
  logic [4:0] hr12;

  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [5:0] tens, units;
    tens  = v / 6'd10;
    units = v - tens * 6'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  always_comb begin
    set_ok = tk_io.set_valid && (tk_io.set_hr <= 5'd23) && (tk_io.set_min <= 6'd59) &&
             (tk_io.set_sec <= 6'd59);
    alm_ok = tk_io.alarm_set && (tk_io.alarm_hr <= 5'd23) && (tk_io.alarm_min <= 6'd59);
    // A rejected load does not block counting.
    inc      = tk_io.run && !set_ok;
    sec_wrap = inc && (sec_q == 6'd59);
    min_wrap = sec_wrap && (min_q == 6'd59);

    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    tick_min_d = sec_wrap;
    tick_hr_d  = min_wrap;
    set_err_d  = (tk_io.set_valid && !set_ok) || (tk_io.alarm_set && !alm_ok);

    if (set_ok) begin
      hr_d  = tk_io.set_hr;
      min_d = tk_io.set_min;
      sec_d = tk_io.set_sec;
    end else if (inc) begin
      if (sec_wrap) begin
        sec_d = 6'd0;
        if (min_wrap) begin
          min_d = 6'd0;
          hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    alm_hr_d  = alm_ok ? tk_io.alarm_hr : alm_hr_q;
    alm_min_d = alm_ok ? tk_io.alarm_min : alm_min_q;

    match = sec_wrap && (hr_d == alm_hr_q) && (min_d == alm_min_q);

    st_d       = st_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    unique case (st_q)
      StRinging: begin
        if (tk_io.stop || !tk_io.alarm_on) begin
          st_d = StIdle;
        end else if (tk_io.snooze) begin
          st_d      = StSnooze;
          snz_cnt_d = SnzLoad;
        end else if (ring_cnt_q == 8'd0) begin
          st_d = StIdle;
        end else begin
          ring_cnt_d = ring_cnt_q - 8'd1;
        end
      end
      StSnooze: begin
        if (tk_io.stop || !tk_io.alarm_on) begin
          st_d = StIdle;
        end else if (snz_cnt_q == 10'd0) begin
          st_d       = StRinging;
          ring_cnt_d = RingLoad;
        end else begin
          snz_cnt_d = snz_cnt_q - 10'd1;
        end
      end
      default: begin
        st_d = StIdle;
        if (tk_io.alarm_on && match) begin
          st_d       = StRinging;
          ring_cnt_d = RingLoad;
        end
      end
    endcase
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      hr_q       <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      alm_hr_q   <= 5'd0;
      alm_min_q  <= 6'd0;
      st_q       <= StIdle;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 10'd0;
      tick_min_q <= 1'b0;
      tick_hr_q  <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      st_q       <= st_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      tick_min_q <= tick_min_d;
      tick_hr_q  <= tick_hr_d;
      set_err_q  <= set_err_d;
    end
  end

  always_comb begin
    hr12 = hr_q;
    if (hr_q == 5'd0) begin
      hr12 = 5'd12;
    end else if (hr_q > 5'd12) begin
      hr12 = hr_q - 5'd12;
    end
    tk_io.sec_bcd = bin2bcd(sec_q);
    tk_io.min_bcd = bin2bcd(min_q);
    if (HOUR_MODE == 12) begin
      tk_io.hr_bcd = bin2bcd({1'b0, hr12});
      tk_io.pm     = (hr_q >= 5'd12);
    end else begin
      tk_io.hr_bcd = bin2bcd({1'b0, hr_q});
      tk_io.pm     = 1'b0;
    end
  end

  assign tk_io.tick_min = tick_min_q;
  assign tk_io.tick_hr  = tick_hr_q;
  assign tk_io.ringing  = (st_q == StRinging);
  assign tk_io.set_err  = set_err_q;

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Directed bench: a 24 h and a 12 h keeper share the same stimulus; short ring/snooze
// periods keep the alarm sequences brief.
module tb_rtc_time_keeper;

  localparam int unsigned RingSec   = 4;
  localparam int unsigned SnoozeSec = 6;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_tick;
  logic [31:0] exp_sec;

  rtc_time_keeper_if bus24 ();
  rtc_time_keeper_if bus12 ();

  assign bus12.run       = bus24.run;
  assign bus12.set_valid = bus24.set_valid;
  assign bus12.set_hr    = bus24.set_hr;
  assign bus12.set_min   = bus24.set_min;
  assign bus12.set_sec   = bus24.set_sec;
  assign bus12.alarm_set = bus24.alarm_set;
  assign bus12.alarm_hr  = bus24.alarm_hr;
  assign bus12.alarm_min = bus24.alarm_min;
  assign bus12.alarm_on  = bus24.alarm_on;
  assign bus12.snooze    = bus24.snooze;
  assign bus12.stop      = bus24.stop;

  rtc_time_keeper #(.HOUR_MODE(24), .RING_SEC(RingSec), .SNOOZE_SEC(SnoozeSec)) dut24 (
    .clk_1Hz(clk),
    .rst    (rst),
    .tk_io  (bus24)
  );

  rtc_time_keeper #(.HOUR_MODE(12), .RING_SEC(RingSec), .SNOOZE_SEC(SnoozeSec)) dut12 (
    .clk_1Hz(clk),
    .rst    (rst),
    .tk_io  (bus12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus24.set_valid = 1'b1;
    bus24.set_hr    = h;
    bus24.set_min   = m;
    bus24.set_sec   = s;
    tick();
    bus24.set_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus24.run       = 1'b0;
    bus24.set_valid = 1'b0;
    bus24.set_hr    = 5'd0;
    bus24.set_min   = 6'd0;
    bus24.set_sec   = 6'd0;
    bus24.alarm_set = 1'b0;
    bus24.alarm_hr  = 5'd0;
    bus24.alarm_min = 6'd0;
    bus24.alarm_on  = 1'b0;
    bus24.snooze    = 1'b0;
    bus24.stop      = 1'b0;
    #2;
    chk("rst_sec", bus24.sec_bcd, 8'h00);
    chk("rst_min", bus24.min_bcd, 8'h00);
    chk("rst_hr24", bus24.hr_bcd, 8'h00);
    chk("rst_hr12", bus12.hr_bcd, 8'h12);
    chk("rst_pm12", bus12.pm, 1'b0);
    chk("rst_ticks", {bus24.tick_min, bus24.tick_hr}, 2'b00);
    chk("rst_ring_err", {bus24.ringing, bus24.set_err}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Sixty seconds of counting: one minute carry.
    bus24.run = 1'b1;
    n_tick = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      exp_sec = 32'(((k % 60) / 10) * 16 + (k % 60) % 10);
      chk("sec_count", bus24.sec_bcd, exp_sec);
      if (bus24.tick_min) n_tick++;
    end
    chk("tick_min_once", n_tick, 1);
    chk("min_after_60", bus24.min_bcd, 8'h01);
    tick();
    chk("tick_min_single", bus24.tick_min, 1'b0);

    // Day rollover.
    load_time(5'd23, 6'd59, 6'd58);
    chk("load_hr24", bus24.hr_bcd, 8'h23);
    chk("load_min", bus24.min_bcd, 8'h59);
    chk("load_sec", bus24.sec_bcd, 8'h58);
    chk("load_hr12", {bus12.pm, bus12.hr_bcd}, 9'h111);
    chk("load_no_tick", bus24.tick_min, 1'b0);
    tick();
    chk("sec_59", bus24.sec_bcd, 8'h59);
    tick();
    chk("roll_time", {bus24.hr_bcd, bus24.min_bcd, bus24.sec_bcd}, 24'h000000);
    chk("roll_ticks", {bus24.tick_min, bus24.tick_hr}, 2'b11);
    chk("roll_hr12", {bus12.pm, bus12.hr_bcd}, 9'h012);
    tick();
    chk("roll_ticks_drop", {bus24.tick_min, bus24.tick_hr}, 2'b00);

    // Out-of-range loads.
    bus24.set_valid = 1'b1;
    bus24.set_hr    = 5'd5;
    bus24.set_min   = 6'd60;
    bus24.set_sec   = 6'd0;
    tick();
    bus24.set_valid = 1'b0;
    chk("bad_set_err", bus24.set_err, 1'b1);
    chk("bad_set_time", {bus24.hr_bcd, bus24.min_bcd, bus24.sec_bcd}, 24'h000002);
    tick();
    chk("set_err_pulse", bus24.set_err, 1'b0);
    chk("bad_set_cont", bus24.sec_bcd, 8'h03);
    load_time(5'd13, 6'd0, 6'd0);
    chk("hr13_24", {bus24.pm, bus24.hr_bcd}, 9'h013);
    chk("hr13_12", {bus12.pm, bus12.hr_bcd}, 9'h101);
    bus24.alarm_set = 1'b1;
    bus24.alarm_hr  = 5'd24;
    bus24.alarm_min = 6'd0;
    tick();
    bus24.alarm_set = 1'b0;
    chk("bad_alarm_err", bus24.set_err, 1'b1);

    // Alarm 07:30 rings, then auto-stops.
    bus24.alarm_set = 1'b1;
    bus24.alarm_hr  = 5'd7;
    bus24.alarm_min = 6'd30;
    bus24.alarm_on  = 1'b1;
    tick();
    bus24.alarm_set = 1'b0;
    chk("alarm_ok_err", bus24.set_err, 1'b0);
    load_time(5'd7, 6'd30, 6'd0);
    chk("load_no_ring", bus24.ringing, 1'b0);
    load_time(5'd7, 6'd29, 6'd59);
    chk("pre_ring", bus24.ringing, 1'b0);
    tick();
    chk("ring_start", bus24.ringing, 1'b1);
    chk("ring_time", {bus24.hr_bcd, bus24.min_bcd, bus24.sec_bcd}, 24'h073000);
    for (int i = 1; i < RingSec; i++) begin
      tick();
      chk("ring_hold", bus24.ringing, 1'b1);
    end
    tick();
    chk("ring_auto_stop", bus24.ringing, 1'b0);

    // Snooze, re-ring, then snooze+stop.
    load_time(5'd7, 6'd29, 6'd59);
    tick();
    chk("ring2_start", bus24.ringing, 1'b1);
    bus24.snooze = 1'b1;
    tick();
    bus24.snooze = 1'b0;
    chk("snooze_quiet", bus24.ringing, 1'b0);
    for (int i = 1; i < SnoozeSec; i++) begin
      tick();
      chk("snooze_hold", bus24.ringing, 1'b0);
    end
    tick();
    chk("snooze_rering", bus24.ringing, 1'b1);
    bus24.snooze = 1'b1;
    bus24.stop   = 1'b1;
    tick();
    bus24.snooze = 1'b0;
    bus24.stop   = 1'b0;
    chk("stop_wins", bus24.ringing, 1'b0);
    n_tick = 0;
    for (int i = 0; i < SnoozeSec + 2; i++) begin
      tick();
      if (bus24.ringing) n_tick++;
    end
    chk("stop_no_rering", n_tick, 0);

    // Asynchronous reset mid-snooze.
    load_time(5'd7, 6'd29, 6'd59);
    tick();
    bus24.snooze = 1'b1;
    tick();
    bus24.snooze = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_snz_time", {bus24.hr_bcd, bus24.min_bcd, bus24.sec_bcd}, 24'h000000);
    chk("arst_snz_hr12", {bus12.pm, bus12.hr_bcd}, 9'h012);
    @(negedge clk);
    rst = 1'b0;
    bus24.run = 1'b0;
    n_tick = 0;
    for (int i = 0; i < SnoozeSec + 2; i++) begin
      tick();
      if (bus24.ringing) n_tick++;
    end
    chk("arst_snz_idle", n_tick, 0);

    // Alarm register reset to 00:00; async reset while ringing and running.
    bus24.run = 1'b1;
    load_time(5'd23, 6'd59, 6'd59);
    tick();
    chk("midnight_ring", bus24.ringing, 1'b1);
    tick();
    tick();
    chk("run_sec2", bus24.sec_bcd, 8'h02);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_run_sec", bus24.sec_bcd, 8'h00);
    chk("arst_run_ring", bus24.ringing, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_sec", bus24.sec_bcd, 8'h01);
    chk("post_rst_ring", bus24.ringing, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
